// File: rtl/animation_pkg.sv
// Shared types and constants for the animation sequencer: FSM states,
// index/frame widths and the per-animation frame counts.
package animation_pkg;

   localparam int IDX_W        = 4;
   localparam int FRAME_W      = 5;
   localparam int PLAY_W       = 4;
   localparam int NUM_ANIM_DEF = 11;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      PAUSE  = 2'd1,
      SWITCH = 2'd2
   } state_t;

   localparam logic [FRAME_W-1:0] LIM_A0    = 5'd10;
   localparam logic [FRAME_W-1:0] LIM_A1    = 5'd12;
   localparam logic [FRAME_W-1:0] LIM_A2_6  = 5'd6;
   localparam logic [FRAME_W-1:0] LIM_A7    = 5'd2;
   localparam logic [FRAME_W-1:0] LIM_A8_9  = 5'd4;
   localparam logic [FRAME_W-1:0] LIM_A10   = 5'd2;
   localparam logic [FRAME_W-1:0] LIM_OTHER = 5'd31;

endpackage

// File: rtl/frame_limit_lut.sv
// Purely combinational frame-count lookup: animation index in, number of
// frames in that animation out.
module frame_limit_lut
   import animation_pkg::*;
(
   input  logic [IDX_W-1:0]   idx,
   output logic [FRAME_W-1:0] limit
);

   always_comb begin
      case (idx)
         4'd0:                         limit = LIM_A0;
         4'd1:                         limit = LIM_A1;
         4'd2, 4'd3, 4'd4, 4'd5, 4'd6: limit = LIM_A2_6;
         4'd7:                         limit = LIM_A7;
         4'd8, 4'd9:                   limit = LIM_A8_9;
         4'd10:                        limit = LIM_A10;
         default:                      limit = LIM_OTHER;
      endcase
   end

endmodule

// File: rtl/animation_sequencer.sv
// Frame/animation sequencer: steps frames on tick, counts plays, and switches
// animations either automatically after REPEATS plays or on manual selection.
module animation_sequencer
   import animation_pkg::*;
#(
   parameter int NUM_ANIM = NUM_ANIM_DEF,
   parameter int REPEATS  = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tick,
   input  logic               auto_mode,
   input  logic [IDX_W-1:0]   anim_sel,
   input  logic               hold,
   output logic [IDX_W-1:0]   animation,
   output logic [FRAME_W-1:0] frame,
   output logic [FRAME_W-1:0] limit,
   output logic               anim_done
);

   localparam logic [IDX_W:0]    NUM_ANIM_X = (IDX_W+1)'(NUM_ANIM);
   localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_ANIM - 1);
   localparam logic [PLAY_W-1:0] REPEATS_W  = PLAY_W'(REPEATS);

   state_t              state, state_nxt;
   logic [IDX_W-1:0]    anim_nxt, target_q, target_nxt;
   logic [IDX_W-1:0]    sel_target, auto_target;
   logic [FRAME_W-1:0]  frame_nxt;
   logic [PLAY_W-1:0]   plays, plays_nxt, plays_inc;
   logic                done_nxt, manual_req, last_frame;

   frame_limit_lut u_lut (
      .idx   (animation),
      .limit (limit)
   );

   // Out-of-range selections map to animation 0, and the comparison uses the
   // mapped value so a bad anim_sel cannot keep re-triggering SWITCH.
   assign sel_target  = ({1'b0, anim_sel} < NUM_ANIM_X) ? anim_sel : '0;
   assign auto_target = (animation == LAST_IDX) ? '0 : animation + 4'd1;
   assign manual_req  = !auto_mode && (sel_target != animation);
   assign last_frame  = (frame == limit - 5'd1);
   assign plays_inc   = (plays == REPEATS_W) ? plays : plays + 4'd1;

   always_comb begin
      state_nxt  = state;
      anim_nxt   = animation;
      frame_nxt  = frame;
      plays_nxt  = plays;
      target_nxt = target_q;
      done_nxt   = 1'b0;
      case (state)
         RUN: begin
            if (!hold && tick) begin
               if (last_frame) begin
                  frame_nxt = '0;
                  done_nxt  = 1'b1;
                  plays_nxt = plays_inc;
                  if (auto_mode && plays_inc == REPEATS_W) begin
                     state_nxt  = SWITCH;
                     target_nxt = auto_target;
                  end
               end else begin
                  frame_nxt = frame + 5'd1;
               end
            end
            // A manual request overrides; any wrap above still completes.
            if (manual_req) begin
               state_nxt  = SWITCH;
               target_nxt = sel_target;
            end else if (hold) begin
               state_nxt = PAUSE;
            end
         end
         PAUSE: begin
            if (manual_req) begin
               state_nxt  = SWITCH;
               target_nxt = sel_target;
            end else if (!hold) begin
               state_nxt = RUN;
            end
         end
         SWITCH: begin
            anim_nxt  = target_q;
            frame_nxt = '0;
            plays_nxt = '0;
            state_nxt = hold ? PAUSE : RUN;
         end
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         animation <= '0;
         frame     <= '0;
         plays     <= '0;
         target_q  <= '0;
         anim_done <= 1'b0;
      end else begin
         state     <= state_nxt;
         animation <= anim_nxt;
         frame     <= frame_nxt;
         plays     <= plays_nxt;
         target_q  <= target_nxt;
         anim_done <= done_nxt;
      end
   end

endmodule
